traffic_phase_scheduler: RTL and testbench

Cycle-accurate phase scheduler for one four-approach intersection. It shares the single right-of-way among the NS, SN, EW and WE approaches using round-robin arbitration over latched stop-line requests (S1), with queue-driven green extension (S5). It enforces min/max green, yellow and all-red clearance, and drives the per-approach 2-bit light outputs plus an observable state code.

---
 rtl/traffic_pkg.sv | 36 +++
 rtl/rr_arbiter_4.sv | 27 ++
 rtl/traffic_phase_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the four-approach phase scheduler.
//   - light codes driven on the per-approach outputs
//   - direction indices (NS=0, SN=1, EW=2, WE=3)
//   - phase codes and the phase_t typedef
//   - light_code(): decodes one approach's light from the registered phase/dir
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic [1:0] DIR_NS = 2'd0;
  localparam logic [1:0] DIR_SN = 2'd1;
  localparam logic [1:0] DIR_EW = 2'd2;
  localparam logic [1:0] DIR_WE = 2'd3;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_t;

  // Only the approach that owns the right-of-way can be non-RED.
  function automatic logic [1:0] light_code(input phase_t ph, input logic [1:0] dir,
                                            input logic [1:0] me);
    logic [1:0] code;
    code = RED;
    if (dir == me) begin
      if (ph == PH_GREEN)       code = GREEN;
      else if (ph == PH_YELLOW) code = YELLOW;
    end
    return code;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational four-way round-robin arbiter.
//   req[3:0]        pending requests, one bit per direction
//   last[1:0]       most recently served direction; search starts at last+1
//   grant_dir[1:0]  winning direction (equals last when nothing is requested)
//   any             at least one request present
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant_dir,
  output logic       any
);

  logic [1:0] w_idx;

  // Walk from lowest priority (last itself) to highest (last+1); the final
  // hit overwrites earlier ones, so the highest-priority request wins.
  always_comb begin
    grant_dir = last;
    any       = |req;
    w_idx     = '0;
    for (int i = 4; i >= 1; i--) begin
      w_idx = last + i[1:0];
      if (req[w_idx]) grant_dir = w_idx;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: phase scheduler for one four-approach intersection.
// Round-robin service of latched stop-line requests (S1_*), queue-driven green
// extension (S5_*), min/max green, yellow and all-red clearance.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   S1_NS/SN/EW/WE           vehicle present at stop line
//   S5_NS/SN/EW/WE           queue reaches 5th-car sensor
//   current_state[3:0]       {phase, dir}
//   NS/SN/EW/WE_light[1:0]   per-approach light (RED/YELLOW/GREEN)
//   emg_req, emg_dir[1:0]    emergency preemption, only when
//                            TRAFFIC_EMERGENCY_PREEMPT_EN is defined
//
// state  | meaning
// IDLE   | nothing pending, all RED
// GREEN  | dir holds right-of-way; timer counts green cycles, saturating
// YELLOW | dir shows YELLOW for YELLOW_T cycles
// ALLRED | all RED for ALLRED_T cycles, then next winner or IDLE
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       S1_NS,
  input  logic       S1_SN,
  input  logic       S1_EW,
  input  logic       S1_WE,
  input  logic       S5_NS,
  input  logic       S5_SN,
  input  logic       S5_EW,
  input  logic       S5_WE,
  output logic [3:0] current_state,
  output logic [1:0] NS_light,
  output logic [1:0] SN_light,
  output logic [1:0] EW_light,
  output logic [1:0] WE_light
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
  ,
  input  logic       emg_req,
  input  logic [1:0] emg_dir
`endif
);

  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_T - 1);

  phase_t          r_phase, w_phase_nxt;
  logic [1:0]      r_dir, w_dir_nxt;
  logic [1:0]      r_last, w_last_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [3:0]      r_pend, w_pend_nxt;
  logic [3:0]      w_s1, w_s5, w_dir_mask, w_green_mask, w_enter;
  logic            w_others, w_any, w_sel_any, w_go_green;
  logic [1:0]      w_grant, w_sel_dir;

  assign w_s1         = {S1_WE, S1_EW, S1_SN, S1_NS};
  assign w_s5         = {S5_WE, S5_EW, S5_SN, S5_NS};
  assign w_dir_mask   = 4'b0001 << r_dir;
  assign w_green_mask = (r_phase == PH_GREEN) ? w_dir_mask : 4'b0000;
  assign w_others     = |(r_pend & ~w_dir_mask);

  rr_arbiter_4 u_arb (
    .req       (r_pend),
    .last      (r_last),
    .grant_dir (w_grant),
    .any       (w_any)
  );

`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
  logic       r_emg_pend, w_preempt;
  logic [1:0] r_emg_dir;

  assign w_preempt = (r_phase == PH_GREEN) && emg_req && (emg_dir != r_dir);
  // A preempted green hands the next ALLRED exit to the emergency direction.
  assign w_sel_dir = r_emg_pend ? r_emg_dir : w_grant;
  assign w_sel_any = r_emg_pend | w_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_emg_pend <= 1'b0;
      r_emg_dir  <= DIR_NS;
    end else if (w_preempt) begin
      r_emg_pend <= 1'b1;
      r_emg_dir  <= emg_dir;
    end else if (w_go_green) begin
      r_emg_pend <= 1'b0;
    end
  end
`else
  assign w_sel_dir = w_grant;
  assign w_sel_any = w_any;
`endif

  always_comb begin
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_last_nxt  = r_last;
    w_timer_nxt = r_timer;
    w_go_green  = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        w_timer_nxt = '0;
        w_go_green  = w_sel_any;
      end
      PH_GREEN: begin
        w_timer_nxt = (r_timer == MAX_LAST) ? r_timer : r_timer + 1'b1;
        // Once past minimum green, leave only if someone else waits and the
        // queue has cleared or the maximum green is reached.
        if (r_timer >= MIN_LAST && w_others && (!w_s5[r_dir] || r_timer == MAX_LAST)) begin
          w_phase_nxt = PH_YELLOW;
          w_timer_nxt = '0;
        end
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
        if (w_preempt) begin
          w_phase_nxt = PH_YELLOW;
          w_timer_nxt = '0;
        end else if (emg_req && emg_dir == r_dir) begin
          w_phase_nxt = PH_GREEN;
          w_timer_nxt = MIN_LAST;
        end
`endif
      end
      PH_YELLOW: begin
        if (r_timer == YEL_LAST) begin
          w_phase_nxt = PH_ALLRED;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (r_timer == AR_LAST) begin
          w_timer_nxt = '0;
          w_phase_nxt = PH_IDLE;
          w_go_green  = w_sel_any;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_phase_nxt = PH_IDLE;
        w_timer_nxt = '0;
      end
    endcase
    // last_dir tracks the direction holding (or last holding) right-of-way,
    // so the arbiter always searches from the one after it.
    if (w_go_green) begin
      w_phase_nxt = PH_GREEN;
      w_dir_nxt   = w_sel_dir;
      w_last_nxt  = w_sel_dir;
      w_timer_nxt = '0;
    end
  end

  assign w_enter    = w_go_green ? (4'b0001 << w_sel_dir) : 4'b0000;
  assign w_pend_nxt = (r_pend | (w_s1 & ~w_green_mask)) & ~w_enter;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= PH_IDLE;
      r_dir   <= DIR_NS;
      r_last  <= DIR_WE;
      r_timer <= '0;
      r_pend  <= 4'b0000;
    end else begin
      r_phase <= w_phase_nxt;
      r_dir   <= w_dir_nxt;
      r_last  <= w_last_nxt;
      r_timer <= w_timer_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign current_state = {r_phase, r_dir};
  assign NS_light      = light_code(r_phase, r_dir, DIR_NS);
  assign SN_light      = light_code(r_phase, r_dir, DIR_SN);
  assign EW_light      = light_code(r_phase, r_dir, DIR_EW);
  assign WE_light      = light_code(r_phase, r_dir, DIR_WE);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  localparam logic [1:0] P_IDLE = 2'd0, P_G = 2'd1, P_Y = 2'd2, P_A = 2'd3;
  localparam logic [1:0] D_NS = 2'd0, D_SN = 2'd1, D_EW = 2'd2, D_WE = 2'd3;

  logic       clk, rst;
  logic       S1_NS, S1_SN, S1_EW, S1_WE;
  logic       S5_NS, S5_SN, S5_EW, S5_WE;
  logic [3:0] current_state;
  logic [1:0] NS_light, SN_light, EW_light, WE_light;
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
  logic       emg_req;
  logic [1:0] emg_dir;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .S1_NS         (S1_NS),
    .S1_SN         (S1_SN),
    .S1_EW         (S1_EW),
    .S1_WE         (S1_WE),
    .S5_NS         (S5_NS),
    .S5_SN         (S5_SN),
    .S5_EW         (S5_EW),
    .S5_WE         (S5_WE),
    .current_state (current_state),
    .NS_light      (NS_light),
    .SN_light      (SN_light),
    .EW_light      (EW_light),
    .WE_light      (WE_light)
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
    ,
    .emg_req       (emg_req),
    .emg_dir       (emg_dir)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h want=%02h", tag, obs, exp);
    end
  endtask

  // Expected lights follow directly from the expected phase/dir.
  task automatic chk_state(input string tag, input logic [1:0] ph, input logic [1:0] dir);
    logic [7:0] exp_l;
    int d;
    d = int'(dir);
    exp_l = 8'h00;
    if (ph == P_G)      exp_l[(3-d)*2 +: 2] = 2'b10;
    else if (ph == P_Y) exp_l[(3-d)*2 +: 2] = 2'b01;
    chk({tag, "_state"}, {4'b0000, current_state}, {4'b0000, ph, dir});
    chk({tag, "_lights"}, {NS_light, SN_light, EW_light, WE_light}, exp_l);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check n consecutive cycles of one phase, advancing one edge after each.
  task automatic hold(input string tag, input logic [1:0] ph, input logic [1:0] dir, input int n);
    for (int i = 0; i < n; i++) begin
      chk_state($sformatf("%s_c%0d", tag, i + 1), ph, dir);
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    {S1_NS, S1_SN, S1_EW, S1_WE} = 4'b0000;
    {S5_NS, S5_SN, S5_EW, S5_WE} = 4'b0000;
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
    emg_req = 1'b0;
    emg_dir = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", P_IDLE, D_NS);
    rst = 1'b1;
    step();
    hold("idle_no_req", P_IDLE, D_NS, 3);

    // Single request: one cycle of latch latency, then NS holds green alone.
    S1_NS = 1'b1;
    chk_state("req_sample", P_IDLE, D_NS);
    step();
    S1_NS = 1'b0;
    chk_state("req_latched", P_IDLE, D_NS);
    step();
    hold("ns_hold", P_G, D_NS, 20);

    // Three simultaneous requests while NS green: SN, EW, WE in RR order.
    {S1_SN, S1_EW, S1_WE} = 3'b111;
    chk_state("rr_pulse", P_G, D_NS);
    step();
    {S1_SN, S1_EW, S1_WE} = 3'b000;
    chk_state("rr_latched", P_G, D_NS);
    step();
    hold("rr_ns_y", P_Y, D_NS, 2);
    hold("rr_ns_a", P_A, D_NS, 1);
    hold("rr_sn_g", P_G, D_SN, 4);
    hold("rr_sn_y", P_Y, D_SN, 2);
    hold("rr_sn_a", P_A, D_SN, 1);
    hold("rr_ew_g", P_G, D_EW, 4);
    hold("rr_ew_y", P_Y, D_EW, 2);
    hold("rr_ew_a", P_A, D_EW, 1);
    hold("rr_we_g", P_G, D_WE, 6);

    // Hand over to NS, then extension to max green with S5_NS held.
    S1_NS = 1'b1;
    chk_state("we_to_ns_pulse", P_G, D_WE);
    step();
    S1_NS = 1'b0;
    chk_state("we_to_ns_latched", P_G, D_WE);
    step();
    hold("we_y", P_Y, D_WE, 2);
    hold("we_a", P_A, D_WE, 1);
    S5_NS = 1'b1;
    S1_EW = 1'b1;
    chk_state("ext_max_c1", P_G, D_NS);
    step();
    S1_EW = 1'b0;
    hold("ext_max", P_G, D_NS, 11);
    S5_NS = 1'b0;
    hold("ext_max_y", P_Y, D_NS, 2);
    hold("ext_max_a", P_A, D_NS, 1);

    // EW minimum green back to NS, then extension cut short by S5 drop.
    S1_NS = 1'b1;
    chk_state("ew_min_c1", P_G, D_EW);
    step();
    S1_NS = 1'b0;
    hold("ew_min", P_G, D_EW, 3);
    hold("ew_min_y", P_Y, D_EW, 2);
    hold("ew_min_a", P_A, D_EW, 1);
    S5_NS = 1'b1;
    S1_SN = 1'b1;
    chk_state("ext_drop_c1", P_G, D_NS);
    step();
    S1_SN = 1'b0;
    hold("ext_drop", P_G, D_NS, 5);
    S5_NS = 1'b0;
    chk_state("ext_drop_c7", P_G, D_NS);
    step();
    hold("ext_drop_y", P_Y, D_NS, 2);
    hold("ext_drop_a", P_A, D_NS, 1);

    // SN served, then NS; NS re-requests through its own yellow/all-red.
    S1_NS = 1'b1;
    chk_state("sn_c1", P_G, D_SN);
    step();
    S1_NS = 1'b0;
    hold("sn_g", P_G, D_SN, 3);
    hold("sn_y", P_Y, D_SN, 2);
    hold("sn_a", P_A, D_SN, 1);
    S1_EW = 1'b1;
    chk_state("rereq_ns_c1", P_G, D_NS);
    step();
    S1_EW = 1'b0;
    S1_NS = 1'b1;
    hold("rereq_ns_g", P_G, D_NS, 3);
    hold("rereq_ns_y", P_Y, D_NS, 2);
    hold("rereq_ns_a", P_A, D_NS, 1);
    S1_NS = 1'b0;
    hold("rereq_ew_g", P_G, D_EW, 4);
    hold("rereq_ew_y", P_Y, D_EW, 2);
    hold("rereq_ew_a", P_A, D_EW, 1);
    hold("rereq_ns_again", P_G, D_NS, 5);

    // Asynchronous reset mid-green: outputs drop before any clock edge.
    #3;
    rst = 1'b0;
    #1;
    chk_state("async_rst", P_IDLE, D_NS);
    step();
    rst = 1'b1;
    step();
    hold("post_rst_idle", P_IDLE, D_NS, 3);

    // last_dir back to WE after reset: NS beats WE (WE would win from NS).
    S1_NS = 1'b1;
    S1_WE = 1'b1;
    step();
    S1_NS = 1'b0;
    S1_WE = 1'b0;
    chk_state("post_rst_latched", P_IDLE, D_NS);
    step();
    hold("post_rst_ns_g", P_G, D_NS, 4);
    hold("post_rst_ns_y", P_Y, D_NS, 2);
    hold("post_rst_ns_a", P_A, D_NS, 1);
    hold("post_rst_we_g", P_G, D_WE, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
